// File: rtl/riscv_datapath.sv
// Single-cycle RV32I-style datapath: register file, immediate generator, ALU,
// write-back mux and PC. The control signals come from an external decoder.
module riscv_datapath #(
  parameter int unsigned          DATAWIDTH  = 32,
  parameter logic [DATAWIDTH-1:0] INITIAL_PC = 32'h00400000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 PCSrc,
  input  logic                 ALUSrc,
  input  logic                 RegWrite,
  input  logic                 MemToReg,
  input  logic [3:0]           ALUCtrl,
  input  logic                 loadPC,
  input  logic [DATAWIDTH-1:0] dReadData,
  output logic [DATAWIDTH-1:0] PC,
  output logic                 Zero,
  output logic [DATAWIDTH-1:0] dAddress,
  output logic [DATAWIDTH-1:0] dWriteData,
  output logic [DATAWIDTH-1:0] WriteBackData
);

  localparam int unsigned DW = DATAWIDTH;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLT = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SRL = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_SRA = 4'b1010
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_JALR   = 7'b1100111,
    OP_SYSTEM = 7'b1110011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  // Instruction fields
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;
  logic [6:0] opcode;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];
  assign opcode   = instr[6:0];

  // funct3/funct7 are decoded upstream into ALUCtrl.
  logic unused_funct3;
  assign unused_funct3 = ^instr[14:12];

  // State
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] regs_q [32];
  logic [DW-1:0] regs_d [32];

  assign PC = pc_q;

  // Register reads: x0 is hard-wired to zero independently of storage.
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs_q[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs_q[rs2_addr];

  // Immediate generation
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] imm_b_ext;
  logic [12:0]   imm_b;

  assign imm_b     = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_b_ext = {{(DW-13){imm_b[12]}}, imm_b};

  // NOTE: every signal written in an always_comb gets a default on entry so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    imm_ext = '0;
    unique case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm_ext = {{(DW-12){instr[31]}}, instr[31:20]};
      OP_STORE:
        imm_ext = {{(DW-12){instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm_ext = imm_b_ext;
      default:
        imm_ext = '0;
    endcase
  end

  // ALU
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [4:0]    shamt;
  logic [DW-1:0] alu_result;

  assign op_a  = rs1_data;
  assign op_b  = ALUSrc ? imm_ext : rs2_data;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(ALUCtrl))
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_XOR: alu_result = op_a ^ op_b;
      ALU_SRL: alu_result = op_a >> shamt;
      ALU_SLL: alu_result = op_a << shamt;
      ALU_SRA: alu_result = $signed(op_a) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  assign Zero          = (alu_result == '0);
  assign dAddress      = alu_result;
  assign dWriteData    = rs2_data;
  assign WriteBackData = MemToReg ? dReadData : alu_result;

  // Next-state logic for the PC and register file
  always_comb begin
    pc_d = pc_q;
    if (loadPC) begin
      pc_d = PCSrc ? (pc_q + imm_b_ext) : (pc_q + DW'(4));
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (rd_addr != 5'd0)) begin
      regs_d[rd_addr] = WriteBackData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  // NOTE: the register file is reset here because software relies on all registers reading zero after reset; most memories would not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= INITIAL_PC;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      regs_q <= regs_d;
    end
  end

endmodule

// File: tb/tb_riscv_datapath.sv
// Self-checking bench for riscv_datapath: a reference model of the architectural
// state plus per-cycle comparisons and directed literal checks.
module tb_riscv_datapath;

  localparam logic [31:0] INIT_PC = 32'h00400000;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC;
  logic [3:0]  ALUCtrl;
  logic [31:0] dReadData;
  logic [31:0] PC, dAddress, dWriteData, WriteBackData;
  logic        Zero;

  riscv_datapath #(.DATAWIDTH(32), .INITIAL_PC(INIT_PC)) dut (
    .clk(clk), .rst(rst), .instr(instr), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .MemToReg(MemToReg), .ALUCtrl(ALUCtrl),
    .loadPC(loadPC), .dReadData(dReadData), .PC(PC), .Zero(Zero),
    .dAddress(dAddress), .dWriteData(dWriteData), .WriteBackData(WriteBackData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: architectural registers and PC.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : m_regs[idx];
  endfunction

  function automatic logic [31:0] m_bimm(input logic [31:0] ins);
    int v;
    v = (int'(ins[11:8]) << 1) | (int'(ins[30:25]) << 5) | (int'(ins[7]) << 11);
    if (ins[31]) v = v - 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin
        v = int'(ins[31:20]);
        if (ins[31]) v = v - 4096;
        return 32'(v);
      end
      7'h23: begin
        v = int'({ins[31:25], ins[11:7]});
        if (ins[31]) v = v - 4096;
        return 32'(v);
      end
      7'h63:   return m_bimm(ins);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_alu();
    logic [31:0] a, b;
    logic signed [31:0] sa;
    a  = m_read(instr[19:15]);
    b  = ALUSrc ? m_imm(instr) : m_read(instr[24:20]);
    sa = a;
    case (ALUCtrl)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd5:    return a ^ b;
      4'd8:    return a >> b[4:0];
      4'd9:    return a << b[4:0];
      4'd10:   return sa >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wb();
    return MemToReg ? dReadData : m_alu();
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= INIT_PC;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
    end else begin
      if (loadPC) m_pc <= PCSrc ? (m_pc + m_bimm(instr)) : (m_pc + 32'd4);
      if (RegWrite && instr[11:7] != 5'd0) m_regs[instr[11:7]] <= m_wb();
    end
  end

  // Per-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (started) begin
      check("cyc_pc", PC, m_pc);
      check("cyc_wb", WriteBackData, m_wb());
      check("cyc_daddr", dAddress, m_alu());
      check("cyc_dwdata", dWriteData, m_read(instr[24:20]));
      check("cyc_zero", {31'b0, Zero}, {31'b0, (m_alu() == 32'h0)});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ctl(input logic [31:0] ins, input logic alusrc, input logic [3:0] ctrl,
                         input logic rw, input logic m2r, input logic ld, input logic psrc);
    instr = ins; ALUSrc = alusrc; ALUCtrl = ctrl; RegWrite = rw;
    MemToReg = m2r; loadPC = ld; PCSrc = psrc;
  endtask

  // Reads register idx through the ALU (rs1 OR x0) with no state update enabled.
  task automatic read_reg(input int idx, input logic [31:0] exp, input string name);
    set_ctl(32'(idx) << 15, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check(name, dAddress, exp);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  ctrl;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  alu_vec_t alu_vecs [12];

  initial begin
    alu_vecs[0]  = '{32'h00208233, 4'b0000, 32'h00000001, "and"};
    alu_vecs[1]  = '{32'h00208233, 4'b0001, 32'hFFFFFFFF, "or"};
    alu_vecs[2]  = '{32'h00208233, 4'b0010, 32'h00000000, "add_wrap"};
    alu_vecs[3]  = '{32'h00208233, 4'b0110, 32'hFFFFFFFE, "sub"};
    alu_vecs[4]  = '{32'h00208233, 4'b0100, 32'h00000001, "slt_neg_lt_pos"};
    alu_vecs[5]  = '{32'h00110233, 4'b0100, 32'h00000000, "slt_pos_lt_neg"};
    alu_vecs[6]  = '{32'h00208233, 4'b0101, 32'hFFFFFFFE, "xor"};
    alu_vecs[7]  = '{32'h00208233, 4'b1000, 32'h7FFFFFFF, "srl"};
    alu_vecs[8]  = '{32'h00208233, 4'b1001, 32'hFFFFFFFE, "sll"};
    alu_vecs[9]  = '{32'h00208233, 4'b1010, 32'hFFFFFFFF, "sra"};
    alu_vecs[10] = '{32'h00208233, 4'b1111, 32'h00000000, "undef_1111"};
    alu_vecs[11] = '{32'h00208233, 4'b0011, 32'h00000000, "undef_0011"};

    rst = 1'b0; dReadData = 32'h0;
    set_ctl(32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    started = 1'b1;
    check("reset_pc_no_edge", PC, 32'h00400000);
    for (int i = 1; i < 32; i++) read_reg(i, 32'h0, $sformatf("reset_x%0d", i));
    step();
    rst = 1'b0;

    // addi x1,x0,5 with PC+4
    set_ctl(32'h00500093, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 check("addi_wb_before_edge", WriteBackData, 32'd5);
    step();
    check("addi_pc", PC, 32'h00400004);
    read_reg(1, 32'd5, "addi_x1");

    // addi x2,x0,7
    set_ctl(32'h00700113, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    read_reg(2, 32'd7, "addi_x2");

    // sw x2,8(x1)
    set_ctl(32'h0020A423, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("sw_daddr", dAddress, 32'd13);
    check("sw_dwdata", dWriteData, 32'd7);
    step();
    read_reg(1, 32'd5, "sw_x1_kept");
    read_reg(2, 32'd7, "sw_x2_kept");

    // lw x3,0(x1) then lw x0,0(x1)
    dReadData = 32'hDEADBEEF;
    set_ctl(32'h0000A183, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 check("lw_wb", WriteBackData, 32'hDEADBEEF);
    step();
    read_reg(3, 32'hDEADBEEF, "lw_x3");
    set_ctl(32'h0000A003, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    read_reg(0, 32'h0, "lw_x0_zero");
    dReadData = 32'h0;

    // beq x1,x1,+8 taken from 0x00400004; branch uses the B immediate with ALUSrc=0
    set_ctl(32'h00108463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 check("beq_zero", {31'b0, Zero}, 32'd1);
    step();
    check("beq_taken_pc", PC, 32'h0040000C);

    // x1=-1, x2=1, then R-type sweep
    set_ctl(32'hFFF00093, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_ctl(32'h00100113, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    read_reg(1, 32'hFFFFFFFF, "x1_minus1");
    foreach (alu_vecs[k]) begin
      set_ctl(alu_vecs[k].ins, 1'b0, alu_vecs[k].ctrl, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      check({"alu_", alu_vecs[k].name}, dAddress, alu_vecs[k].exp);
      check({"zero_", alu_vecs[k].name}, {31'b0, Zero}, {31'b0, (alu_vecs[k].exp == 32'h0)});
    end
    step();

    // Reset in the middle of a pending PC/register update
    set_ctl(32'h00900293, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 check("midreset_pc", PC, INIT_PC);
    step();
    rst = 1'b0;
    #1 check("midreset_pc_held", PC, INIT_PC);
    read_reg(5, 32'h0, "midreset_x5");
    read_reg(1, 32'h0, "midreset_x1");
    set_ctl(32'h00900293, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    check("resume_pc", PC, 32'h00400004);
    read_reg(5, 32'd9, "resume_x5");

    // x1=5, then beq not taken (PCSrc=0) from 0x00400004
    set_ctl(32'h00500093, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_ctl(32'h00108463, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 check("beq2_zero", {31'b0, Zero}, 32'd1);
    step();
    check("beq_notsel_pc", PC, 32'h00400008);

    // Backward branch by -8
    set_ctl(32'hFE000CE3, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("branch_back_pc", PC, 32'h00400000);

    set_ctl(32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
